memory_address_unit: RTL and testbench

- Sits directly downstream of the program counter in the SAP-2 datapath.
- Holds the 16-bit memory address (MAR) and runs single-byte read/write transactions to external memory through a req/ack handshake.
- Captures read data in a memory data register (MDR) and can drive the MDR onto the low byte of the W bus.
- The MAR loads either the full PC value (instruction fetch) or byte-wise from the W bus low byte (operand/jump address assembly).

---
 rtl/memory_address_unit.sv | 139 +++++++++++++
 tb/tb_memory_address_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/memory_address_unit.sv
// Memory address unit: MAR/MDR pair running single-byte req/ack memory
// transactions for the SAP-2 datapath. All state updates on the falling edge.
module memory_address_unit #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic [ADDR_W-1:0] iProgramCounter,
  input  logic              iLoadPC,
  input  logic              iLoadLow,
  input  logic              iLoadHigh,
  input  logic [DATA_W-1:0] iWbus,
  input  logic              iRead,
  input  logic              iWrite,
  input  logic [DATA_W-1:0] iWriteData,
  input  logic              eData,
  input  logic              iMemAck,
  input  logic [DATA_W-1:0] iMemRdata,
  output logic [ADDR_W-1:0] oAddress,
  output logic              oMemReq,
  output logic              oMemWe,
  output logic [DATA_W-1:0] oMemWdata,
  output logic [DATA_W-1:0] oReadData,
  output logic              oBusy,
  output logic              oDone,
  output logic              oError,
  output tri   [DATA_W-1:0] tWbus
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   mar_q;
  logic [ADDR_W-1:0]   txn_addr_q;
  logic [DATA_W-1:0]   mdr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                req_q;
  logic                we_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                timeout_hit;

  // Saturating increment of the ACCESS wait counter and timeout detection.
  always_comb begin
    cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    timeout_hit = (TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT));
  end

  // MAR/MDR and transaction FSM; all outputs are registered.
  always_ff @(negedge iClk or negedge iReset) begin
    if (!iReset) begin
      state_q    <= S_IDLE;
      mar_q      <= '0;
      txn_addr_q <= '0;
      mdr_q      <= '0;
      wdata_q    <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (iLoadPC) begin
            mar_q <= iProgramCounter;
          end else begin
            if (iLoadLow)  mar_q[7:0]        <= iWbus;
            if (iLoadHigh) mar_q[ADDR_W-1:8] <= iWbus;
          end
          if (iWrite || iRead) begin
            // The transaction address is the MAR before any same-edge load.
            txn_addr_q <= mar_q;
            state_q    <= S_ACCESS;
            req_q      <= 1'b1;
            busy_q     <= 1'b1;
            we_q       <= iWrite;
            cnt_q      <= '0;
            if (iWrite) wdata_q <= iWriteData;
          end
        end
        S_ACCESS: begin
          if (iMemAck) begin
            if (!we_q) mdr_q <= iMemRdata;
            state_q <= S_DONE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (timeout_hit) begin
            error_q <= 1'b1;
            state_q <= S_DONE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          we_q    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Outside IDLE the address is held at the in-flight transaction address.
  assign oAddress  = (state_q == S_IDLE) ? mar_q : txn_addr_q;
  assign oMemReq   = req_q;
  assign oMemWe    = we_q;
  assign oMemWdata = wdata_q;
  assign oReadData = mdr_q;
  assign oBusy     = busy_q;
  assign oDone     = done_q;
  assign oError    = error_q;

  assign tWbus = eData ? mdr_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_memory_address_unit.sv
// Directed self-checking bench for memory_address_unit.
module tb_memory_address_unit;

  logic        iClk = 1'b1;
  logic        iReset;
  logic [15:0] iProgramCounter;
  logic        iLoadPC, iLoadLow, iLoadHigh;
  logic [7:0]  iWbus;
  logic        iRead, iWrite;
  logic [7:0]  iWriteData;
  logic        eData;
  logic        iMemAck;
  logic [7:0]  iMemRdata;
  logic [15:0] oAddress;
  logic        oMemReq, oMemWe;
  logic [7:0]  oMemWdata, oReadData;
  logic        oBusy, oDone, oError;
  wire  [7:0]  tWbus;

  int errors = 0;
  int checks = 0;

  memory_address_unit #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(15)) dut (
    .iClk(iClk), .iReset(iReset), .iProgramCounter(iProgramCounter),
    .iLoadPC(iLoadPC), .iLoadLow(iLoadLow), .iLoadHigh(iLoadHigh),
    .iWbus(iWbus), .iRead(iRead), .iWrite(iWrite), .iWriteData(iWriteData),
    .eData(eData), .iMemAck(iMemAck), .iMemRdata(iMemRdata),
    .oAddress(oAddress), .oMemReq(oMemReq), .oMemWe(oMemWe),
    .oMemWdata(oMemWdata), .oReadData(oReadData), .oBusy(oBusy),
    .oDone(oDone), .oError(oError), .tWbus(tWbus)
  );

  always #5 iClk = ~iClk;

  // DUT updates on negedge; the bench samples and drives on posedge.
  task automatic tick();
    @(posedge iClk);
  endtask

  task automatic test_reset();
    iReset = 1'b0; iProgramCounter = '0; iLoadPC = 0; iLoadLow = 0; iLoadHigh = 0;
    iWbus = '0; iRead = 0; iWrite = 0; iWriteData = '0; eData = 1'b1;
    iMemAck = 0; iMemRdata = '0;
    #12;
    checks++; if (oAddress !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected 0000", oAddress); end
    checks++; if ({oMemReq, oMemWe, oBusy, oDone, oError} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {oMemReq, oMemWe, oBusy, oDone, oError}); end
    checks++; if (oReadData !== 8'h00 || oMemWdata !== 8'h00) begin errors++; $display("FAIL reset_data: got %h/%h expected 00/00", oReadData, oMemWdata); end
    checks++; if (tWbus !== 8'h00) begin errors++; $display("FAIL reset_twbus: got %h expected 00", tWbus); end
    eData = 1'b0;
    tick();
    iReset = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    iProgramCounter = 16'h1234; iLoadPC = 1;
    tick();
    iLoadPC = 0;
    checks++; if (oAddress !== 16'h1234) begin errors++; $display("FAIL fetch_addr: got %h expected 1234", oAddress); end
    iRead = 1;
    tick();
    iRead = 0;
    checks++; if (oMemReq !== 1'b1 || oBusy !== 1'b1 || oMemWe !== 1'b0) begin errors++; $display("FAIL fetch_req1: got req=%b busy=%b we=%b expected 1 1 0", oMemReq, oBusy, oMemWe); end
    tick();
    checks++; if (oMemReq !== 1'b1 || oDone !== 1'b0) begin errors++; $display("FAIL fetch_req2: got req=%b done=%b expected 1 0", oMemReq, oDone); end
    iMemAck = 1; iMemRdata = 8'hA5;
    tick();
    iMemAck = 0; iMemRdata = 8'h00;
    checks++; if (oMemReq !== 1'b0 || oDone !== 1'b1 || oBusy !== 1'b0) begin errors++; $display("FAIL fetch_done: got req=%b done=%b busy=%b expected 0 1 0", oMemReq, oDone, oBusy); end
    checks++; if (oReadData !== 8'hA5) begin errors++; $display("FAIL fetch_mdr: got %h expected a5", oReadData); end
    tick();
    checks++; if (oDone !== 1'b0 || oMemReq !== 1'b0) begin errors++; $display("FAIL fetch_pulse: got done=%b req=%b expected 0 0", oDone, oMemReq); end
    eData = 1; #1;
    checks++; if (tWbus !== 8'hA5) begin errors++; $display("FAIL twbus_on: got %h expected a5", tWbus); end
    eData = 0; #1;
    checks++; if (tWbus === 8'hA5) begin errors++; $display("FAIL twbus_off: got %h expected released bus", tWbus); end
    tick();
  endtask

  task automatic test_byte_write();
    iWbus = 8'h5E; iLoadLow = 1; iLoadHigh = 1;
    tick();
    checks++; if (oAddress !== 16'h5E5E) begin errors++; $display("FAIL both_bytes: got %h expected 5e5e", oAddress); end
    iLoadHigh = 0; iLoadPC = 1; iProgramCounter = 16'h0F0F;
    tick();
    checks++; if (oAddress !== 16'h0F0F) begin errors++; $display("FAIL pc_priority: got %h expected 0f0f", oAddress); end
    iLoadPC = 0; iWbus = 8'hCD; iLoadLow = 1;
    tick();
    iLoadLow = 0; iWbus = 8'hAB; iLoadHigh = 1;
    tick();
    iLoadHigh = 0;
    checks++; if (oAddress !== 16'hABCD) begin errors++; $display("FAIL byte_addr: got %h expected abcd", oAddress); end
    iWrite = 1; iWriteData = 8'h5A;
    tick();
    iWrite = 0; iWriteData = 8'h00;
    for (int i = 0; i < 3; i++) begin
      checks++; if (oMemReq !== 1'b1 || oMemWe !== 1'b1 || oMemWdata !== 8'h5A || oAddress !== 16'hABCD) begin
        errors++; $display("FAIL write_access%0d: got req=%b we=%b wd=%h addr=%h expected 1 1 5a abcd", i, oMemReq, oMemWe, oMemWdata, oAddress);
      end
      if (i == 2) begin iMemAck = 1; iMemRdata = 8'h11; end
      tick();
    end
    iMemAck = 0;
    checks++; if (oDone !== 1'b1 || oReadData !== 8'hA5) begin errors++; $display("FAIL write_done: got done=%b mdr=%h expected 1 a5", oDone, oReadData); end
    tick();
    checks++; if (oMemWe !== 1'b0 || oDone !== 1'b0) begin errors++; $display("FAIL write_we_clr: got we=%b done=%b expected 0 0", oMemWe, oDone); end
  endtask

  task automatic test_busy_lockout();
    iRead = 1;
    tick();
    iRead = 0;
    iLoadPC = 1; iProgramCounter = 16'hFFFF; iRead = 1; iWrite = 1; iWriteData = 8'hEE;
    tick();
    checks++; if (oAddress !== 16'hABCD || oMemWe !== 1'b0 || oMemReq !== 1'b1) begin errors++; $display("FAIL lock_access: got addr=%h we=%b req=%b expected abcd 0 1", oAddress, oMemWe, oMemReq); end
    iMemAck = 1; iMemRdata = 8'h77;
    tick();
    iMemAck = 0;
    checks++; if (oDone !== 1'b1 || oReadData !== 8'h77 || oAddress !== 16'hABCD) begin errors++; $display("FAIL lock_done: got done=%b mdr=%h addr=%h expected 1 77 abcd", oDone, oReadData, oAddress); end
    iLoadPC = 0; iRead = 0; iWrite = 0;
    tick();
    checks++; if (oAddress !== 16'hABCD || oMemReq !== 1'b0 || oDone !== 1'b0 || oBusy !== 1'b0) begin errors++; $display("FAIL lock_idle: got addr=%h req=%b done=%b busy=%b expected abcd 0 0 0", oAddress, oMemReq, oDone, oBusy); end
    tick();
    checks++; if (oMemReq !== 1'b0 || oMemWdata !== 8'h5A) begin errors++; $display("FAIL lock_noreq: got req=%b wd=%h expected 0 5a", oMemReq, oMemWdata); end
  endtask

  task automatic test_timeout();
    int acc = 0;
    bit seen = 0;
    iRead = 1;
    tick();
    iRead = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (oDone) seen = 1;
      else begin
        if (oMemReq) acc++;
        tick();
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL timeout_done: got no done within 40 cycles expected done"); end
    checks++; if (acc !== 15) begin errors++; $display("FAIL timeout_cycles: got %0d expected 15", acc); end
    checks++; if (oError !== 1'b1 || oReadData !== 8'h77) begin errors++; $display("FAIL timeout_err: got err=%b mdr=%h expected 1 77", oError, oReadData); end
    tick();
    checks++; if (oError !== 1'b1) begin errors++; $display("FAIL error_sticky: got %b expected 1", oError); end
    iRead = 1;
    tick();
    iRead = 0; iMemAck = 1; iMemRdata = 8'h3C;
    tick();
    iMemAck = 0;
    checks++; if (oDone !== 1'b1 || oReadData !== 8'h3C || oError !== 1'b1) begin errors++; $display("FAIL post_timeout_read: got done=%b mdr=%h err=%b expected 1 3c 1", oDone, oReadData, oError); end
    tick();
  endtask

  task automatic test_rw_simul();
    iMemAck = 1; iMemRdata = 8'hF0;
    iRead = 1; iWrite = 1; iWriteData = 8'h99;
    tick();
    iRead = 0; iWrite = 0;
    checks++; if (oMemWe !== 1'b1 || oBusy !== 1'b1 || oMemWdata !== 8'h99) begin errors++; $display("FAIL rw_access: got we=%b busy=%b wd=%h expected 1 1 99", oMemWe, oBusy, oMemWdata); end
    tick();
    iMemAck = 0;
    checks++; if (oBusy !== 1'b0 || oDone !== 1'b1 || oReadData !== 8'h3C) begin errors++; $display("FAIL rw_done: got busy=%b done=%b mdr=%h expected 0 1 3c", oBusy, oDone, oReadData); end
    tick();
  endtask

  task automatic test_reset_mid();
    iRead = 1;
    tick();
    iRead = 0;
    checks++; if (oMemReq !== 1'b1) begin errors++; $display("FAIL mid_req: got %b expected 1", oMemReq); end
    #2 iReset = 1'b0;
    #1;
    checks++; if (oMemReq !== 1'b0 || oBusy !== 1'b0 || oError !== 1'b0) begin errors++; $display("FAIL mid_reset_ctrl: got req=%b busy=%b err=%b expected 0 0 0", oMemReq, oBusy, oError); end
    checks++; if (oAddress !== 16'h0000) begin errors++; $display("FAIL mid_reset_addr: got %h expected 0000", oAddress); end
    tick();
    iReset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_byte_write();
    test_busy_lockout();
    test_timeout();
    test_rw_simul();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
